dct_sched: RTL and testbench
============================

# dct_sched

Block-granular round-robin scheduler that shares one 8-point 1-D DCT engine (`dct_ft`) between `N_REQ` component requesters (Y, Cb, Cr). It accepts 8-row blocks over per-requester valid/ready handshakes and streams them contiguously into the engine with generated `sob`/`eob`/`sof` flags. It delays the winner's id through a `PIPE`-deep tag pipeline so that `out_id` is aligned with the engine's result beats.

## Interface
- `W`, 8: samples per row (bytes per beat)
- `PIPE`, 8: engine latency in cycles; must match the engine instance
- `N_REQ`, 3: number of requesters, 2..4
- `clk` in 1: the single clock
- `rst` in 1: reset, asynchronous, active-high. One clock `clk`; reset `rst` is asynchronous and active-high.
- `req_valid` in `N_REQ`: requester has a row
- `req_ready` out `N_REQ`: row accepted this cycle when valid&ready
- `req_data` in `N_REQ`×`W`×8: row samples, unsigned
- `req_sof` in `N_REQ`: first block of frame; sampled on row 0 only
- `eng_valid`, `eng_sob`, `eng_eob`, `eng_sof` out 1 each: to engine `in_*`
- `eng_data` out `W`×8: to engine `in_data`
- `eng_res_valid` in 1: engine `out_valid`, used for checking only
- `out_valid` out 1: tag pipeline valid, aligned with engine result
- `out_id` out clog2(`N_REQ`): requester owning the current result row
- `tag_err` out 1: sticky; set when `eng_res_valid` != `out_valid`

## Operation
- FSM states: IDLE and BUSY. Reset state is IDLE, `row`=0, `rr_ptr`=0.
- IDLE:
  - If any `req_valid` is set, grant the first valid requester at or after `rr_ptr` in cyclic order, latch it in `gnt`, and go to BUSY.
  - No row is accepted in the grant cycle.
- BUSY:
  - `req_ready[gnt]`=1; all other `req_ready` bits are 0.
  - Each accepted row drives the registered engine inputs the next cycle with `eng_valid`=1.
  - `eng_sob`=1 on row 0. `eng_eob`=1 on row 7.
  - `eng_sof` = `req_sof[gnt]` sampled at row 0, and is asserted on row 0 only.
  - If `req_valid[gnt]` drops mid-block, the cycle is a bubble: `eng_valid`=0 and `row` holds. The grant is never revoked until row 7 is accepted.
- Row 7 accept:
  - Set `rr_ptr`=`gnt`+1 mod `N_REQ` and `row`=0.
  - Re-arbitrate in the same cycle using the new `rr_ptr` and the current `req_valid`, with the granted requester's bit included.
  - If any valid: stay in BUSY with the new `gnt`, giving back-to-back blocks with no bubble. Otherwise go to IDLE.
- Tag pipeline:
  - `PIPE`+1 stage shift of {accepted, `gnt`}.
  - `out_valid`/`out_id` are taken from the last stage, so they coincide with engine `out_valid`/`out_data`.
- Check: `tag_err` is set on any cycle where `eng_res_valid` != `out_valid`. It is cleared only by `rst`.
- Data is passed through unmodified. The block performs no arithmetic on samples.

## Timing
- Reset values:
  - `req_ready`=0.
  - All `eng_*` outputs = 0, including `eng_data`.
  - `out_valid`=0, `out_id`=0, `tag_err`=0.
  - Tag pipeline cleared.
- Latency:
  - Row accepted at edge t, so `eng_valid`=1 in cycle t+1.
  - Engine result and `out_valid` in cycle t+1+`PIPE`.
- Grant latency from IDLE: 1 cycle (`req_valid` seen at t, `req_ready` at t+1).
- Throughput: one row per cycle sustained. An 8-row block takes 8 cycles when the requester never stalls.
- `req_ready` is registered-state based. It depends only on FSM state, `gnt`, and `row`, and never combinationally on `req_valid`.
- Reset asserted mid-block: the partial block is dropped and the tag pipeline is flushed. The engine shares `rst` (inverted at top), so no stale results emerge.
- `req_sof` on rows 1..7 is ignored.

## Structure
- `dct_sched_pkg`:
  - `state_t` enum {IDLE, BUSY}
  - `localparam ROWS = 8`
  - `id_t` width function of `N_REQ`
- Sub-module `rr_arbiter` (combinational, `N_REQ`-wide):
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot grant and encoded id.
  - Used in both IDLE and row-7 re-arbitration.
- Top holds the FSM, row counter, engine-input registers, tag shift register and the check logic.

## Test plan
- Single requester 0: 8 consecutive rows 0x10..0x17 with `req_sof`=1.
  - `eng_sob` on beat 1, `eng_eob` on beat 8, `eng_sof` only with `sob`.
  - `out_id`=0 for 8 cycles starting `PIPE`+1 cycles after the first accept.
- All 3 requesters continuously valid for 6 blocks.
  - Grant order 0,1,2,0,1,2.
  - `eng_valid` unbroken for 48 cycles.
  - `out_id` sequence matches in 8-cycle runs.
- Requester 1 drops valid for 3 cycles after row 3.
  - 3 bubbles on `eng_valid`, `row` resumes at 4.
  - Requester 2, although valid, is not granted until row 7 of requester 1 is accepted.
- Requester 2 alone, then requester 0 asserts valid on the row-7 accept cycle of 2.
  - Back-to-back grant to 0, no bubble.
- Assert `rst` for 1 cycle at row 5 with results in flight.
  - All outputs 0 on the next cycle, FSM in IDLE, `out_valid` stays 0 for `PIPE`+1 cycles.
- Force `eng_res_valid`=1 while the tag pipeline is empty.
  - `tag_err`=1 and stays 1 until `rst`.

Source files
------------

// File: rtl/dct_sched_pkg.sv
// dct_sched_pkg
// Shared types and constants for the DCT engine scheduler.
//   state_t  : scheduler FSM states (IDLE, BUSY)
//   ROWS     : rows per 8x8 block handed to the 1-D DCT engine
//   id_width : width of a requester id for a given requester count
package dct_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int ROWS = 8;

    // Requester id width; a single requester still needs one bit.
    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/dct_sched_if.sv
// dct_sched_if
// Per-requester row handshake bundle between the component sources (Y, Cb, Cr)
// and the scheduler.
//   req_valid : requester has a row
//   req_ready : scheduler takes the row when valid & ready
//   req_data  : row samples, W bytes per requester
//   req_sof   : first block of frame, meaningful on row 0 only
// Modports: master = requester side, slave = scheduler side.
interface dct_sched_if
    import dct_sched_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int W     = 8
) ();

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][W*8-1:0]   req_data;
    logic [N_REQ-1:0]            req_sof;

    modport master (
        output req_valid,
        output req_data,
        output req_sof,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_sof,
        output req_ready
    );

endinterface

// File: rtl/dct_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: grants the first set bit of req at or after
// ptr, wrapping cyclically over N_REQ requesters.
//   req    : request vector
//   ptr    : highest-priority requester index
//   gnt_oh : one-hot grant (all zero when nothing requests)
//   gnt_id : encoded grant index
//   any    : at least one request is set
module rr_arbiter
    import dct_sched_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]              req,
    input  logic [id_width(N_REQ)-1:0]    ptr,
    output logic [N_REQ-1:0]              gnt_oh,
    output logic [id_width(N_REQ)-1:0]    gnt_id,
    output logic                          any
);

    localparam int ID_W = id_width(N_REQ);

    logic found_s;
    int   ptr_c_s;
    int   idx_s;

    assign any = |req;

    // Cyclic scan starting at ptr; first hit wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        idx_s   = 0;
        // An out-of-range pointer is treated as requester 0.
        if (int'(ptr) < N_REQ) begin
            ptr_c_s = int'(ptr);
        end else begin
            ptr_c_s = 0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = ptr_c_s + k;
            if (idx_s >= N_REQ) begin
                idx_s = idx_s - N_REQ;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s]) begin
                found_s        = 1'b1;
                gnt_oh[idx_s]  = 1'b1;
                gnt_id         = ID_W'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/dct_sched.sv
// dct_sched
// Block-granular round-robin scheduler sharing one 8-point 1-D DCT engine
// between N_REQ component requesters. Whole 8-row blocks are streamed into
// the engine with generated sob/eob/sof, and the owner id is delayed through
// a PIPE+1 stage tag pipeline so out_id lines up with engine result beats.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req           : requester handshake bundle (slave side)
//   eng_valid/sob/eob/sof, eng_data : registered engine inputs
//   eng_res_valid : engine out_valid, compared against the tag pipeline
//   out_valid     : tag pipeline valid, aligned with the engine result
//   out_id        : requester owning the current result row
//   tag_err       : sticky, engine result valid disagreed with tag pipeline
module dct_sched
    import dct_sched_pkg::*;
#(
    parameter int W     = 8,
    parameter int PIPE  = 8,
    parameter int N_REQ = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    dct_sched_if.slave                    req,
    output logic                          eng_valid,
    output logic                          eng_sob,
    output logic                          eng_eob,
    output logic                          eng_sof,
    output logic [W*8-1:0]                eng_data,
    input  logic                          eng_res_valid,
    output logic                          out_valid,
    output logic [id_width(N_REQ)-1:0]    out_id,
    output logic                          tag_err
);

    localparam int                ID_W     = id_width(N_REQ);
    localparam int                RW       = $clog2(ROWS);
    localparam int                DW       = W * 8;
    localparam logic [RW-1:0]     LAST_ROW = RW'(ROWS - 1);
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_REQ - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ID_W-1:0]    gnt_r;
    logic [ID_W-1:0]    gnt_nxt_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    rr_ptr_nxt_s;
    logic [RW-1:0]      row_r;
    logic [RW-1:0]      row_nxt_s;
    logic [N_REQ-1:0]   ready_r;
    logic [N_REQ-1:0]   ready_nxt_s;

    logic               accept_s;
    logic               last_s;
    logic [ID_W-1:0]    ptr_inc_s;
    logic [ID_W-1:0]    arb_ptr_s;
    logic [N_REQ-1:0]   arb_oh_s;
    logic [ID_W-1:0]    arb_id_s;
    logic               arb_any_s;

    logic               eng_valid_r;
    logic               eng_sob_r;
    logic               eng_eob_r;
    logic               eng_sof_r;
    logic [DW-1:0]      eng_data_r;

    logic               tag_v_r  [PIPE+1];
    logic [ID_W-1:0]    tag_id_r [PIPE+1];
    logic               tag_err_r;

    // ready_r is one-hot on gnt while BUSY, so this is the row transfer.
    assign accept_s  = (state_r == BUSY) && req.req_valid[gnt_r];
    assign last_s    = accept_s && (row_r == LAST_ROW);
    assign ptr_inc_s = (gnt_r == LAST_ID) ? '0 : gnt_r + ID_W'(1);

    // During the row-7 accept the pointer that takes effect is gnt+1, so the
    // re-arbitration already uses it; in IDLE the stored pointer applies.
    assign arb_ptr_s = (state_r == BUSY) ? ptr_inc_s : rr_ptr_r;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req.req_valid),
        .ptr    (arb_ptr_s),
        .gnt_oh (arb_oh_s),
        .gnt_id (arb_id_s),
        .any    (arb_any_s)
    );

    assign req.req_ready = ready_r;

    assign eng_valid = eng_valid_r;
    assign eng_sob   = eng_sob_r;
    assign eng_eob   = eng_eob_r;
    assign eng_sof   = eng_sof_r;
    assign eng_data  = eng_data_r;
    assign out_valid = tag_v_r[PIPE];
    assign out_id    = tag_id_r[PIPE];
    assign tag_err   = tag_err_r;

    // Next-state, grant, row counter and next ready vector.
    always_comb begin
        state_nxt_s  = state_r;
        gnt_nxt_s    = gnt_r;
        row_nxt_s    = row_r;
        rr_ptr_nxt_s = rr_ptr_r;
        ready_nxt_s  = ready_r;
        case (state_r)
            IDLE: begin
                // Grant only; the first row is taken the following cycle.
                if (arb_any_s) begin
                    state_nxt_s = BUSY;
                    gnt_nxt_s   = arb_id_s;
                    ready_nxt_s = arb_oh_s;
                end else begin
                    ready_nxt_s = '0;
                end
            end
            BUSY: begin
                if (last_s) begin
                    row_nxt_s    = '0;
                    rr_ptr_nxt_s = ptr_inc_s;
                    // The finishing requester's own valid is part of this
                    // vote, so it keeps the grant when nobody else asks.
                    if (arb_any_s) begin
                        gnt_nxt_s   = arb_id_s;
                        ready_nxt_s = arb_oh_s;
                    end else begin
                        state_nxt_s = IDLE;
                        ready_nxt_s = '0;
                    end
                end else if (accept_s) begin
                    row_nxt_s = row_r + RW'(1);
                end else begin
                    // Requester stalled: bubble, row and grant hold.
                    row_nxt_s = row_r;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                gnt_nxt_s    = '0;
                row_nxt_s    = '0;
                rr_ptr_nxt_s = '0;
                ready_nxt_s  = '0;
            end
        endcase
    end

    // FSM, grant, pointer, row and ready registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            gnt_r    <= '0;
            rr_ptr_r <= '0;
            row_r    <= '0;
            ready_r  <= '0;
        end else begin
            state_r  <= state_nxt_s;
            gnt_r    <= gnt_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            row_r    <= row_nxt_s;
            ready_r  <= ready_nxt_s;
        end
    end

    // Engine input registers: one beat per accepted row, zeroed on bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_valid_r <= 1'b0;
            eng_sob_r   <= 1'b0;
            eng_eob_r   <= 1'b0;
            eng_sof_r   <= 1'b0;
            eng_data_r  <= '0;
        end else begin
            eng_valid_r <= accept_s;
            eng_sob_r   <= accept_s && (row_r == '0);
            eng_eob_r   <= last_s;
            // req_sof is only meaningful on the first row of a block.
            eng_sof_r   <= accept_s && (row_r == '0) && req.req_sof[gnt_r];
            eng_data_r  <= accept_s ? req.req_data[gnt_r] : '0;
        end
    end

    // Tag shift register: stage 0 captures this cycle's accept, the last
    // stage lands in the same cycle as the engine result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= PIPE; i++) begin
                tag_v_r[i]  <= 1'b0;
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_v_r[0]  <= accept_s;
            tag_id_r[0] <= gnt_r;
            for (int i = 1; i <= PIPE; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Sticky alignment check between engine result valid and tag pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_err_r <= 1'b0;
        end else begin
            tag_err_r <= tag_err_r | (eng_res_valid != tag_v_r[PIPE]);
        end
    end

endmodule

// File: tb/tb_dct_sched.sv
// tb_dct_sched
// Directed bench for dct_sched with a scoreboard: each accepted row pushes its
// expected engine beat and result tag (with the cycle they must appear), and
// the checker pops them when the DUT outputs are due. The engine is modelled
// as a PIPE-cycle delay of eng_valid.
module tb_dct_sched;
    import dct_sched_pkg::*;

    localparam int W     = 8;
    localparam int PIPE  = 8;
    localparam int N_REQ = 3;
    localparam int DW    = W * 8;
    localparam int ID_W  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            eng_valid, eng_sob, eng_eob, eng_sof;
    logic [DW-1:0]   eng_data;
    logic            eng_res_valid;
    logic            out_valid;
    logic [ID_W-1:0] out_id;
    logic            tag_err;

    always #5 clk = ~clk;

    dct_sched_if #(.N_REQ(N_REQ), .W(W)) ifc ();

    dct_sched #(.W(W), .PIPE(PIPE), .N_REQ(N_REQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (ifc),
        .eng_valid     (eng_valid),
        .eng_sob       (eng_sob),
        .eng_eob       (eng_eob),
        .eng_sof       (eng_sof),
        .eng_data      (eng_data),
        .eng_res_valid (eng_res_valid),
        .out_valid     (out_valid),
        .out_id        (out_id),
        .tag_err       (tag_err)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sob;
        logic          eob;
        logic          sof;
        int            cyc;
    } beat_t;

    typedef struct {
        int id;
        int cyc;
    } tag_t;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rd [N_REQ][64];
    logic          rs [N_REQ][64];
    int            head [N_REQ];
    int            tail [N_REQ];
    int            rowcnt [N_REQ];
    int            hold_cnt [N_REQ];

    beat_t bq[$];
    tag_t  tq[$];
    int    owner_q[$];

    logic evh [PIPE+1];
    logic force_res;
    logic exp_err;
    int   cyc;
    int   run_len, max_run, gaps;
    logic in_blk;
    int   first_acc;
    int   hold_req, hold_row, hold_len;
    int   gate_req, gate_src, gate_row;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_block(input int id, input logic sof_first, input logic [7:0] base, input bit rnd);
        for (int r = 0; r < ROWS; r++) begin
            if (rnd) begin
                rd[id][tail[id]] = {$urandom, $urandom};
            end else begin
                rd[id][tail[id]] = {W{base + 8'(r)}};
            end
            // Rows 1..7 carry sof=1 on purpose: it must not reach the engine.
            rs[id][tail[id]] = (r == 0) ? sof_first : 1'b1;
            tail[id]++;
        end
    endtask

    function automatic bit pending();
        bit p = (bq.size() > 0) || (tq.size() > 0);
        for (int i = 0; i < N_REQ; i++) begin
            if (head[i] < tail[i]) p = 1'b1;
        end
        return p;
    endfunction

    // One clock: check outputs due this cycle, then drive the next inputs.
    task automatic step();
        beat_t            b;
        tag_t             t;
        logic             exp_ev, exp_ov;
        logic [N_REQ-1:0] v, rdy;
        int               mid, exp_o;
        @(negedge clk);
        cyc++;

        exp_ev = (bq.size() > 0) && (bq[0].cyc == cyc);
        chk("eng_valid", eng_valid, exp_ev);
        if (exp_ev) begin
            b = bq.pop_front();
            chk("eng_data", eng_data, b.data);
            chk("eng_sob", eng_sob, b.sob);
            chk("eng_eob", eng_eob, b.eob);
            chk("eng_sof", eng_sof, b.sof);
        end
        if (eng_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (eng_sob) in_blk = 1'b1;
            if (eng_eob) in_blk = 1'b0;
        end else begin
            run_len = 0;
            if (in_blk) gaps++;
        end

        exp_ov = (tq.size() > 0) && (tq[0].cyc == cyc);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            t = tq.pop_front();
            chk("out_id", out_id, t.id);
        end
        chk("tag_err", tag_err, exp_err);
        chk("ready_onehot0", $onehot0(ifc.req_ready), 1);

        for (int k = PIPE; k > 0; k--) evh[k] = evh[k-1];
        evh[0]        = eng_valid;
        eng_res_valid = evh[PIPE] | force_res;
        exp_err       = exp_err | force_res;

        if (gate_req >= 0 && rowcnt[gate_src] == gate_row && head[gate_src] < tail[gate_src]) begin
            hold_cnt[gate_req] = 0;
            gate_req = -1;
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (hold_cnt[i] > 0) begin
                v[i] = 1'b0;
                hold_cnt[i]--;
            end else begin
                v[i] = (head[i] < tail[i]);
            end
            ifc.req_data[i] = (head[i] < tail[i]) ? rd[i][head[i]] : '0;
            ifc.req_sof[i]  = (head[i] < tail[i]) ? rs[i][head[i]] : 1'b0;
        end
        ifc.req_valid = v;
        rdy = ifc.req_ready;

        for (int i = 0; i < N_REQ; i++) begin
            if (v[i] && rdy[i]) begin
                mid = 0;
                for (int j = 0; j < N_REQ; j++) begin
                    if (j != i && rowcnt[j] != 0) mid = 1;
                end
                chk("no_interleave", mid, 0);
                if (rowcnt[i] == 0) begin
                    exp_o = (owner_q.size() > 0) ? owner_q.pop_front() : -1;
                    chk("grant_order", i, exp_o);
                end
                if (first_acc < 0) first_acc = cyc;
                b.data = rd[i][head[i]];
                b.sob  = (rowcnt[i] == 0);
                b.eob  = (rowcnt[i] == ROWS - 1);
                b.sof  = (rowcnt[i] == 0) && rs[i][head[i]];
                b.cyc  = cyc + 1;
                bq.push_back(b);
                t.id  = i;
                t.cyc = cyc + 1 + PIPE;
                tq.push_back(t);
                head[i]++;
                rowcnt[i] = (rowcnt[i] + 1) % ROWS;
                if (i == hold_req && rowcnt[i] == hold_row) begin
                    hold_cnt[i] = hold_len;
                    hold_req = -1;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", (n < budget), 1);
    endtask

    // One-cycle reset; bench state is flushed along with the DUT.
    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        ifc.req_valid = '0;
        ifc.req_sof   = '0;
        ifc.req_data  = '0;
        bq.delete();
        tq.delete();
        owner_q.delete();
        for (int i = 0; i < N_REQ; i++) begin
            head[i] = 0; tail[i] = 0; rowcnt[i] = 0; hold_cnt[i] = 0;
        end
        for (int k = 0; k <= PIPE; k++) evh[k] = 1'b0;
        eng_res_valid = 1'b0;
        force_res = 1'b0;
        exp_err   = 1'b0;
        in_blk    = 1'b0;
        run_len   = 0;
        hold_req  = -1;
        gate_req  = -1;
        @(negedge clk);
        cyc++;
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_eng_sob", eng_sob, 0);
        chk("rst_eng_eob", eng_eob, 0);
        chk("rst_eng_sof", eng_sof, 0);
        chk("rst_eng_data", eng_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_req_ready", ifc.req_ready, 0);
        chk("rst_state_idle", 64'(dut.state_r), 64'(IDLE));
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int start;
        rst = 1'b1;
        ifc.req_valid = '0;
        ifc.req_sof   = '0;
        ifc.req_data  = '0;
        eng_res_valid = 1'b0;
        force_res = 1'b0;
        exp_err   = 1'b0;
        cyc = 0;
        max_run = 0;
        gaps = 0;
        first_acc = -1;
        hold_req = -1;
        gate_req = -1;
        do_reset();

        // Single requester 0, rows 0x10..0x17, sof on the first block.
        add_block(0, 1'b1, 8'h10, 1'b0);
        owner_q.push_back(0);
        start = cyc + 1;
        first_acc = -1;
        drain(100);
        chk("grant_latency", first_acc, start + 1);

        // All three requesters saturated for six blocks.
        do_reset();
        for (int blk = 0; blk < 2; blk++) begin
            for (int id = 0; id < N_REQ; id++) begin
                add_block(id, (blk == 0), 8'h00, 1'b1);
            end
        end
        for (int blk = 0; blk < 2; blk++) begin
            for (int id = 0; id < N_REQ; id++) owner_q.push_back(id);
        end
        max_run = 0;
        drain(200);
        chk("saturated_run", max_run, 48);

        // Requester 1 stalls 3 cycles after row 3 while requester 2 waits.
        do_reset();
        add_block(1, 1'b1, 8'h30, 1'b0);
        add_block(2, 1'b0, 8'h50, 1'b0);
        owner_q.push_back(1);
        owner_q.push_back(2);
        hold_req = 1; hold_row = 4; hold_len = 3;
        gaps = 0;
        drain(200);
        chk("stall_bubbles", gaps, 3);

        // Requester 2 alone; requester 0 joins on 2's row-7 accept.
        add_block(2, 1'b1, 8'h70, 1'b1);
        add_block(0, 1'b1, 8'h90, 1'b0);
        hold_cnt[0] = 1000;
        gate_req = 0; gate_src = 2; gate_row = ROWS - 1;
        owner_q.push_back(2);
        owner_q.push_back(0);
        max_run = 0;
        drain(200);
        chk("back_to_back_run", max_run, 16);

        // Reset at row 5 with results in flight.
        add_block(0, 1'b1, 8'hA0, 1'b1);
        owner_q.push_back(0);
        n = 0;
        while (rowcnt[0] != 5 && n < 50) begin
            step();
            n++;
        end
        chk("reached_row5", rowcnt[0], 5);
        do_reset();
        for (int k = 0; k <= PIPE; k++) begin
            step();
            chk("flush_out_valid", out_valid, 0);
        end

        // Spurious engine result with an empty tag pipeline.
        force_res = 1'b1;
        step();
        force_res = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("tag_err_sticky", tag_err, 1);
        do_reset();
        step();
        chk("tag_err_cleared", tag_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
